// File: rtl/fft_frame_collector_if.sv
// fft_frame_collector_if
//  Bundles the sample stream, frame handshake and overrun status of the
//  FFT frame collector.
//  Ports (signals):
//   sample_in / sample_valid   codec sample and its 1-cycle strobe
//   frame_data / frame_valid   parallel frame to the FFT and its valid flag
//   frame_ready                consumer accepts the frame
//   fill_level                 samples currently held in the fill bank
//   overrun / overrun_count    sticky drop flag and saturating drop count
//   clear_overrun              synchronous clear of the overrun status
//  Modports: master = sample source / frame consumer, slave = collector.
interface fft_frame_collector_if #(
  parameter int N     = 16,
  parameter int W     = 16,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(N) + 1;

  logic [W-1:0]     sample_in;
  logic             sample_valid;
  logic [N*W-1:0]   frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [LVL_W-1:0] fill_level;
  logic             overrun;
  logic [CNT_W-1:0] overrun_count;
  logic             clear_overrun;

  modport master (
    output sample_in, sample_valid, frame_ready, clear_overrun,
    input  frame_data, frame_valid, fill_level, overrun, overrun_count
  );

  modport slave (
    input  sample_in, sample_valid, frame_ready, clear_overrun,
    output frame_data, frame_valid, fill_level, overrun, overrun_count
  );
endinterface

// File: rtl/fft_frame_collector.sv
// fft_frame_collector
//  Gathers consecutive signed audio samples into N-sample frames and presents
//  each complete frame as one parallel word feeding the FFT inputs t0..tN-1.
//  Samples land in bit-reversed slot order (BIT_REVERSE=1) for a radix-2 DIT
//  first stage. Two banks ping-pong: one fills while the other is held at the
//  output until the consumer takes it.
//  Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      fft_frame_collector_if.slave (sample stream, frame handshake,
//            fill level, overrun status and clear)
module fft_frame_collector #(
  parameter int N           = 16,
  parameter int W           = 16,
  parameter int BIT_REVERSE = 1,
  parameter int CNT_W       = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  fft_frame_collector_if.slave bus
);
  localparam int LOG2N = $clog2(N);
  localparam int LVL_W = LOG2N + 1;

  typedef enum logic {
    ST_FILL,
    ST_FULL
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     bank [2][N];
  logic             fill_sel, fill_sel_next;
  logic [LVL_W-1:0] fill_level, fill_level_next;
  logic             frame_valid, frame_valid_next;
  logic             overrun, overrun_next;
  logic [CNT_W-1:0] overrun_count, overrun_count_next;
  logic             out_free;
  logic             write_en;
  logic             frame_done;
  logic             swap;
  logic             drop;
  logic [LOG2N-1:0] wr_idx;

  // Slot for the next sample: the fill count, optionally bit-reversed.
  always_comb begin
    wr_idx = '0;
    for (int b = 0; b < LOG2N; b++) begin
      if (BIT_REVERSE != 0) wr_idx[b] = fill_level[LOG2N-1-b];
      else                  wr_idx[b] = fill_level[b];
    end
  end

  // Fill-side decision. The swap check is evaluated combinationally both on
  // the edge that completes a frame and on every FULL cycle, so a frame can be
  // handed over in the same clock its last sample is written.
  always_comb begin
    out_free           = !frame_valid || bus.frame_ready;
    write_en           = 1'b0;
    frame_done         = 1'b0;
    drop               = 1'b0;
    swap               = 1'b0;
    state_next         = state;
    fill_level_next    = fill_level;
    fill_sel_next      = fill_sel;
    frame_valid_next   = frame_valid;
    overrun_next       = overrun;
    overrun_count_next = overrun_count;

    case (state)
      ST_FILL: begin
        write_en   = bus.sample_valid;
        frame_done = write_en && (fill_level == LVL_W'(N - 1));
        if (frame_done) begin
          if (out_free) swap = 1'b1;
          else          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // Samples arriving while full are dropped, including in the swap cycle.
        drop = bus.sample_valid;
        if (out_free) begin
          swap       = 1'b1;
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase

    if (swap) begin
      fill_level_next = '0;
      fill_sel_next   = ~fill_sel;
    end else if (write_en) begin
      fill_level_next = fill_level + LVL_W'(1);
    end

    // A swap keeps frame_valid high even when the old frame is taken, giving
    // back-to-back frames.
    if (swap)                            frame_valid_next = 1'b1;
    else if (frame_valid && bus.frame_ready) frame_valid_next = 1'b0;

    // Clear has priority over a drop in the same cycle.
    if (bus.clear_overrun) begin
      overrun_next       = 1'b0;
      overrun_count_next = '0;
    end else if (drop) begin
      overrun_next = 1'b1;
      if (overrun_count != '1) overrun_count_next = overrun_count + CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_FILL;
      fill_sel      <= 1'b0;
      fill_level    <= '0;
      frame_valid   <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_next;
      fill_sel      <= fill_sel_next;
      fill_level    <= fill_level_next;
      frame_valid   <= frame_valid_next;
      overrun       <= overrun_next;
      overrun_count <= overrun_count_next;
    end
  end

  // Sample banks. The write uses the pre-swap fill_sel, so the Nth sample
  // lands in the bank that becomes the output bank at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N; s++) begin
          bank[b][s] <= '0;
        end
      end
    end else if (write_en) begin
      bank[fill_sel][wr_idx] <= bus.sample_in;
    end
  end

  // The output bank is always the one not being filled.
  always_comb begin
    bus.frame_data = '0;
    for (int j = 0; j < N; j++) begin
      bus.frame_data[j*W +: W] = bank[~fill_sel][j];
    end
  end

  assign bus.frame_valid   = frame_valid;
  assign bus.fill_level    = fill_level;
  assign bus.overrun       = overrun;
  assign bus.overrun_count = overrun_count;
endmodule

// File: tb/tb_fft_frame_collector.sv
// tb_fft_frame_collector
//  Directed bench for fft_frame_collector. Drives a bit-reversing instance and
//  a natural-order instance from the same stimulus and compares their outputs
//  against hand-computed frames and status values.
module tb_fft_frame_collector;
  localparam int N     = 16;
  localparam int W     = 16;
  localparam int LOG2N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] sa [N];
  logic [W-1:0] sb [N];

  fft_frame_collector_if #(.N(N), .W(W), .CNT_W(8)) bus ();
  fft_frame_collector_if #(.N(N), .W(W), .CNT_W(8)) bus_nr ();

  // The natural-order instance sees exactly the same inputs.
  assign bus_nr.sample_in     = bus.sample_in;
  assign bus_nr.sample_valid  = bus.sample_valid;
  assign bus_nr.frame_ready   = bus.frame_ready;
  assign bus_nr.clear_overrun = bus.clear_overrun;

  fft_frame_collector #(.N(N), .W(W), .BIT_REVERSE(1), .CNT_W(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  fft_frame_collector #(.N(N), .W(W), .BIT_REVERSE(0), .CNT_W(8)) u_dut_nr (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nr.slave)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N*W-1:0] observed,
                             input logic [N*W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [W-1:0] sample,
                               input logic ready, input logic clr);
    bus.sample_valid  = valid;
    bus.sample_in     = sample;
    bus.frame_ready   = ready;
    bus.clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    bus.frame_ready   = 1'b0;
    bus.clear_overrun = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (k[b]) r = r | (1 << (LOG2N - 1 - b));
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] expectFrame(input logic [W-1:0] s [N], input logic rev);
    logic [N*W-1:0] f = '0;
    for (int k = 0; k < N; k++) begin
      f[(rev ? bitrev(k) : k)*W +: W] = s[k];
    end
    return f;
  endfunction

  function automatic logic [W-1:0] slotOf(input logic [N*W-1:0] f, input int j);
    return f[j*W +: W];
  endfunction

  initial begin
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    bus.frame_ready   = 1'b0;
    bus.clear_overrun = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", bus.frame_valid, 1'b0);
    checkOutput("rst_level", bus.fill_level, 0);
    checkOutput("rst_data", bus.frame_data, '0);
    checkOutput("rst_overrun", bus.overrun, 1'b0);
    checkOutput("rst_count", bus.overrun_count, 0);
    reset_n = 1'b1;

    // Test 1: ramp 1..16, consumer always ready.
    for (int k = 0; k < N; k++) begin
      sa[k] = W'(k + 1);
      applyStimulus(1'b1, W'(k + 1), 1'b1, 1'b0);
      if (k == 4) checkOutput("t1_level5", bus.fill_level, 5);
      if (k == 14) checkOutput("t1_novalid", bus.frame_valid, 1'b0);
    end
    checkOutput("t1_valid", bus.frame_valid, 1'b1);
    checkOutput("t1_level0", bus.fill_level, 0);
    checkOutput("t1_frame", bus.frame_data, expectFrame(sa, 1'b1));
    checkOutput("t1_slot0", slotOf(bus.frame_data, 0), 16'd1);
    checkOutput("t1_slot1", slotOf(bus.frame_data, 1), 16'd9);
    checkOutput("t1_slot2", slotOf(bus.frame_data, 2), 16'd5);
    checkOutput("t1_slot15", slotOf(bus.frame_data, 15), 16'd16);
    checkOutput("t1_nr_frame", bus_nr.frame_data, expectFrame(sa, 1'b0));
    checkOutput("t1_nr_slot5", slotOf(bus_nr.frame_data, 5), 16'd6);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_pulse_end", bus.frame_valid, 1'b0);

    // Test 2: consumer stalled, 40 samples -> frame1 held, frame2 full, 8 drops.
    doReset();
    for (int k = 0; k < 40; k++) begin
      if (k < 16) sa[k] = W'(100 + k);
      else if (k < 32) sb[k - 16] = W'(100 + k);
      applyStimulus(1'b1, W'(100 + k), 1'b0, 1'b0);
      if (k == 15) checkOutput("t2_f1_valid", bus.frame_valid, 1'b1);
    end
    checkOutput("t2_held_frame", bus.frame_data, expectFrame(sa, 1'b1));
    checkOutput("t2_full_level", bus.fill_level, 16);
    checkOutput("t2_overrun", bus.overrun, 1'b1);
    checkOutput("t2_count", bus.overrun_count, 8);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_b2b_valid", bus.frame_valid, 1'b1);
    checkOutput("t2_b2b_frame", bus.frame_data, expectFrame(sb, 1'b1));
    checkOutput("t2_b2b_level", bus.fill_level, 0);
    checkOutput("t2_b2b_count", bus.overrun_count, 8);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_taken", bus.frame_valid, 1'b0);
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
    checkOutput("t2_refill_level", bus.fill_level, 1);
    checkOutput("t2_refill_count", bus.overrun_count, 8);

    // Test 3: a sample every clock with ready high -> a frame every 16 clocks.
    doReset();
    for (int k = 0; k < 48; k++) begin
      sa[k % N] = W'(1000 + k);
      applyStimulus(1'b1, W'(1000 + k), 1'b1, 1'b0);
      if (k % N == N - 1) begin
        checkOutput("t3_valid", bus.frame_valid, 1'b1);
        checkOutput("t3_frame", bus.frame_data, expectFrame(sa, 1'b1));
      end
      if (k % N == 0 && k > 0) checkOutput("t3_taken", bus.frame_valid, 1'b0);
    end
    checkOutput("t3_no_overrun", bus.overrun, 1'b0);
    checkOutput("t3_no_drops", bus.overrun_count, 0);

    // Test 4: extreme values stored bit-exact.
    doReset();
    for (int k = 0; k < N; k++) begin
      sa[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      applyStimulus(1'b1, sa[k], 1'b1, 1'b0);
    end
    checkOutput("t4_frame", bus.frame_data, expectFrame(sa, 1'b1));
    checkOutput("t4_slot0", slotOf(bus.frame_data, 0), 16'h8000);
    checkOutput("t4_slot8", slotOf(bus.frame_data, 8), 16'h7FFF);
    checkOutput("t4_nr_slot1", slotOf(bus_nr.frame_data, 1), 16'h7FFF);

    // Test 5: overrun counter saturation and clear priority.
    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1'b1, W'(k), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
      if (i == 253) checkOutput("t5_count254", bus.overrun_count, 254);
    end
    checkOutput("t5_sat", bus.overrun_count, 255);
    checkOutput("t5_overrun", bus.overrun, 1'b1);
    applyStimulus(1'b1, '0, 1'b0, 1'b1);
    checkOutput("t5_clr_count", bus.overrun_count, 0);
    checkOutput("t5_clr_overrun", bus.overrun, 1'b0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    checkOutput("t5_after_clr", bus.overrun_count, 1);

    // Test 6: asynchronous reset mid-frame with a pending frame.
    doReset();
    for (int k = 0; k < N; k++) applyStimulus(1'b1, W'(200 + k), 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, W'(300 + k), 1'b0, 1'b0);
    checkOutput("t6_pre_level", bus.fill_level, 7);
    checkOutput("t6_pre_valid", bus.frame_valid, 1'b1);
    bus.sample_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", bus.frame_valid, 1'b0);
    checkOutput("t6_async_level", bus.fill_level, 0);
    checkOutput("t6_async_data", bus.frame_data, '0);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      sa[k] = W'(500 + k);
      applyStimulus(1'b1, W'(500 + k), 1'b1, 1'b0);
    end
    checkOutput("t6_valid", bus.frame_valid, 1'b1);
    checkOutput("t6_slot0", slotOf(bus.frame_data, 0), 16'd500);
    checkOutput("t6_frame", bus.frame_data, expectFrame(sa, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
